mult_result_display: RTL and testbench
======================================

Name: mult_result_display

Overview:
- Downstream stage of the 3-bit sign-magnitude multiplier.
- Captures the multiplier's 5-bit result (bit 4 = sign, bits 3:0 = magnitude, legal range 0..9) and its zero flag on a valid strobe.
- Holds the captured result and drives a 2-digit, time-multiplexed, common-anode seven-segment display: digit 0 = magnitude, digit 1 = sign.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays lit before the scan advances; legal range ≥2.
- BLINK_HALF, 12500000, cycles per half-period of the new-result blink; used only when RESULT_BLINK_EN is defined.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  single-cycle strobe: product/zero_flag are valid
- product  input  5  multiplier result; [4] sign, [3:0] magnitude
- zero_flag  input  1  multiplier zero flag
- seg  output  7  active-low segments {g,f,e,d,c,b,a}, registered
- an  output  2  active-low digit enables; [0] magnitude, [1] sign; registered
- result_valid  output  1  high while a captured result is displayed

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - seg = 7'b1111111, an = 2'b11, result_valid = 0.
  - Scan counter = 0, digit index = 0.
  - FSM in BLANK; capture registers cleared.
- FSM states:
  - BLANK: an held 2'b11; scan counter still runs.
  - SHOW: normal display.
- Transitions:
  - BLANK→SHOW on in_valid.
  - SHOW→SHOW on in_valid (recapture).
  - rst from any state → BLANK, including mid-scan or mid-blink.
- Capture:
  - When in_valid=1 at edge N, product and zero_flag are registered at edge N.
  - result_valid = 1 from edge N.
  - seg/an reflect the new value at edge N+1.
  - in_valid is accepted every cycle; no backpressure. Back-to-back strobes: the last one wins.
- Scan:
  - Counter counts 0..REFRESH_DIV-1.
  - At terminal count the counter wraps to 0 and the digit index toggles.
  - an = ~(2'b01 << index) in SHOW, registered, so it lags the index by one cycle.
  - A capture does not reset the scan counter.
- Digit 0 decode, in priority order:
  - zero_flag=1 → '0', regardless of magnitude.
  - Magnitude 0..9 → that digit.
  - Magnitude 10..15 → 'E' (7'b0000110).
- Digit 1 decode:
  - '-' (7'b0111111) if sign=1 and zero_flag=0 and magnitude≠0.
  - Otherwise blank (7'b1111111). Negative zero is never shown.
- Segment codes 0..9, active-low gfedcba: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- seg and an update on the same edge; no ghosting cycle with a stale seg on a new digit.

Optional Feature:
- Macro: RESULT_BLINK_EN.
- Defined:
  - Each capture restarts a blink counter spanning 4*BLINK_HALF cycles.
  - During the 2nd and 4th half-periods, an is forced to 2'b11.
  - result_valid stays 1 throughout.
  - A recapture mid-blink restarts the count.
  - After the 4th half-period, normal display resumes.
- Undefined: no blink logic or counter; display is steady from edge N+1.

Decomposition:
- Package mult_disp_pkg holds:
  - segment constants SEG_DIGIT[0:9], SEG_MINUS, SEG_E, SEG_BLANK;
  - state enum {BLANK, SHOW};
  - field-position constants SIGN_BIT=4, MAG_MSB=3.
- One sub-module, seg7_decoder: combinational, 4-bit value + zero flag → 7-bit active-low segment code for digit 0.
- The FSM, scan counter and optional blink logic stay in the top.

Test Plan (REFRESH_DIV=4, BLINK_HALF=8):
- Reset held 3 cycles then released, no in_valid:
  - seg=1111111, an=11, result_valid=0 indefinitely.
- in_valid with product=5'b10110, zero_flag=0 (−6):
  - result_valid=1 at the capture edge.
  - Next edge: digit 0 shows 0000010.
  - Digit 1 shows 0111111.
  - an alternates 10/01 every 4 cycles.
- product=5'b10000, zero_flag=1 (−0):
  - Digit 0 = 1000000; digit 1 blank 1111111.
- product=5'b01100, zero_flag=0 (illegal 12):
  - Digit 0 = 0000110 ('E'); digit 1 blank.
- Strobes on consecutive cycles, 5'b00011 then 5'b01001:
  - Display settles to 9 (0010000), positive.
  - Assert rst during SHOW: next edge seg=1111111, an=11, result_valid=0.
- RESULT_BLINK_EN defined, capture 5'b00100:
  - an=11 during cycles 9..16 and 25..32 after capture.
  - Steady display from cycle 33 onward.

Source files
------------

// File: rtl/mult_disp_pkg.sv
// Shared constants and types for the multiplier result display: segment codes,
// product field positions and the display FSM state encoding.
package mult_disp_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int unsigned SIGN_BIT = 4;
    localparam int unsigned MAG_MSB  = 3;

    typedef enum logic {
        BLANK,
        SHOW
    } state_e;

endpackage

// File: rtl/seg7_decoder.sv
// Magnitude digit decoder: 4-bit value plus zero flag to active-low gfedcba.
// The zero flag wins over the value; out-of-range magnitudes show 'E'.
module seg7_decoder
    import mult_disp_pkg::*;
(
    input  logic [3:0] i_value,
    input  logic       i_zero,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_E;
        if (i_zero) begin
            o_seg = SEG_DIGIT[0];
        end else begin
            case (i_value)
                4'd0:    o_seg = SEG_DIGIT[0];
                4'd1:    o_seg = SEG_DIGIT[1];
                4'd2:    o_seg = SEG_DIGIT[2];
                4'd3:    o_seg = SEG_DIGIT[3];
                4'd4:    o_seg = SEG_DIGIT[4];
                4'd5:    o_seg = SEG_DIGIT[5];
                4'd6:    o_seg = SEG_DIGIT[6];
                4'd7:    o_seg = SEG_DIGIT[7];
                4'd8:    o_seg = SEG_DIGIT[8];
                4'd9:    o_seg = SEG_DIGIT[9];
                default: o_seg = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/mult_result_display.sv
// Captures the sign-magnitude multiplier result and scans it onto a 2-digit
// common-anode display. Optional new-result blink under `RESULT_BLINK_EN.
module mult_result_display
    import mult_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_HALF  = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [4:0] product,
    input  logic       zero_flag,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       result_valid
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_e           r_state;
    state_e           w_state_next;
    logic [4:0]       r_product;
    logic             r_zero;
    logic             r_result_valid;
    logic [CNT_W-1:0] r_scan_cnt;
    logic             r_digit_idx;
    logic [6:0]       r_seg;
    logic [1:0]       r_an;
    logic [6:0]       w_seg_mag;
    logic [6:0]       w_seg_sign;
    logic [6:0]       w_seg_next;
    logic [1:0]       w_an_next;
    logic             w_blank_an;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BLANK: if (in_valid) w_state_next = SHOW;
            SHOW:  w_state_next = SHOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_product      <= '0;
            r_zero         <= 1'b0;
            r_result_valid <= 1'b0;
        end else if (in_valid) begin
            r_product      <= product;
            r_zero         <= zero_flag;
            r_result_valid <= 1'b1;
        end
    end

    // Free-running scan; a capture deliberately leaves the phase alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= 1'b0;
        end else if (r_scan_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= ~r_digit_idx;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

`ifdef RESULT_BLINK_EN
    localparam int unsigned BLINK_SPAN = 4 * BLINK_HALF;
    localparam int unsigned BLINK_W    = $clog2(BLINK_SPAN + 1);

    logic [BLINK_W-1:0] r_blink_cnt;

    // Saturates at BLINK_SPAN, which means "not blinking".
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= BLINK_W'(BLINK_SPAN);
        end else if (in_valid) begin
            r_blink_cnt <= '0;
        end else if (r_blink_cnt != BLINK_W'(BLINK_SPAN)) begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_blank_an =
        ((r_blink_cnt >= BLINK_W'(BLINK_HALF)) && (r_blink_cnt < BLINK_W'(2 * BLINK_HALF))) ||
        ((r_blink_cnt >= BLINK_W'(3 * BLINK_HALF)) && (r_blink_cnt < BLINK_W'(BLINK_SPAN)));
`else
    logic w_unused_blink_half;
    assign w_unused_blink_half = |BLINK_HALF;
    assign w_blank_an          = 1'b0;
`endif

    seg7_decoder u_seg7_decoder (
        .i_value (r_product[MAG_MSB:0]),
        .i_zero  (r_zero),
        .o_seg   (w_seg_mag)
    );

    // Negative zero is suppressed: minus needs a nonzero magnitude and no zero flag.
    assign w_seg_sign = (r_product[SIGN_BIT] && !r_zero && (r_product[MAG_MSB:0] != '0))
                        ? SEG_MINUS : SEG_BLANK;

    always_comb begin
        w_seg_next = SEG_BLANK;
        w_an_next  = 2'b11;
        if ((r_state == SHOW) && !w_blank_an) begin
            w_an_next  = ~(2'b01 << r_digit_idx);
            w_seg_next = r_digit_idx ? w_seg_sign : w_seg_mag;
        end
    end

    // seg and an share one edge so a new digit never shows a stale pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= SEG_BLANK;
            r_an  <= 2'b11;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign seg          = r_seg;
    assign an           = r_an;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_mult_result_display.sv
// Directed bench for mult_result_display (REFRESH_DIV=4, BLINK_HALF=8) with a
// scoreboard of expected digit patterns per capture.
module tb_mult_result_display;

    localparam int unsigned REFRESH_DIV = 4;
    localparam int unsigned BLINK_HALF  = 8;
`ifdef RESULT_BLINK_EN
    localparam int unsigned SETTLE = 40;
`else
    localparam int unsigned SETTLE = 2;
`endif

    typedef struct packed {
        logic [6:0] d0;
        logic [6:0] d1;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [4:0] product;
    logic       zero_flag;
    logic [6:0] seg;
    logic [1:0] an;
    logic       result_valid;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mult_result_display #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLINK_HALF  (BLINK_HALF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .product      (product),
        .zero_flag    (zero_flag),
        .seg          (seg),
        .an           (an),
        .result_valid (result_valid)
    );

    function automatic logic [6:0] exp_d0(input logic [3:0] m, input logic z);
        if (z) return 7'b1000000;
        case (m)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0000110;
        endcase
    endfunction

    function automatic logic [6:0] exp_d1(input logic [4:0] p, input logic z);
        return (p[4] && !z && (p[3:0] != 4'd0)) ? 7'b0111111 : 7'b1111111;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) tick();
    endtask

    // Drive one strobe; expect result_valid at the capture edge and the new
    // pattern on whichever digit is lit one edge later.
    task automatic cap(input logic [4:0] p, input logic z);
        exp_t e;
        e.d0 = exp_d0(p[3:0], z);
        e.d1 = exp_d1(p, z);
        sb.push_back(e);
        in_valid  = 1'b1;
        product   = p;
        zero_flag = z;
        tick();
        in_valid = 1'b0;
        chk("rv_at_capture", 16'(result_valid), 16'd1);
        tick();
        chk("an_active_n1", 16'((an == 2'b10) || (an == 2'b01)), 16'd1);
        chk("seg_n1", 16'(seg), 16'((an == 2'b10) ? e.d0 : e.d1));
        idle(SETTLE);
    endtask

    // Pop one expected result and watch the scan for n cycles.
    task automatic observe(input int unsigned n);
        exp_t       e;
        logic [1:0] prev;
        int         run;
        bit         seen;
        chk("sb_nonempty", 16'(sb.size() != 0), 16'd1);
        if (sb.size() == 0) return;
        e    = sb.pop_front();
        prev = an;
        run  = 0;
        seen = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            tick();
            chk("rv_held", 16'(result_valid), 16'd1);
            if (an == 2'b10) chk("seg_digit0", 16'(seg), 16'(e.d0));
            else if (an == 2'b01) chk("seg_digit1", 16'(seg), 16'(e.d1));
            else chk("an_onehot", 16'(an), 16'b10);
            if (an != prev) begin
                if (seen) chk("scan_period", 16'(run), 16'(REFRESH_DIV));
                seen = 1'b1;
                run  = 1;
                prev = an;
            end else begin
                run++;
            end
        end
    endtask

    initial begin
        exp_t e;
        rst       = 1'b1;
        in_valid  = 1'b0;
        product   = '0;
        zero_flag = 1'b0;
        idle(3);
        chk("reset_seg", 16'(seg), 16'h7f);
        chk("reset_an", 16'(an), 16'h3);
        chk("reset_rv", 16'(result_valid), 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("idle_blank", {7'd0, seg, an}, {7'd0, 7'h7f, 2'b11});
            chk("idle_rv", 16'(result_valid), 16'd0);
        end

        cap(5'b10110, 1'b0);
        observe(20);
        cap(5'b10000, 1'b1);
        observe(12);
        cap(5'b01100, 1'b0);
        observe(12);
        cap(5'b10101, 1'b1);
        observe(12);
        cap(5'b01001, 1'b0);
        observe(12);

        // Back-to-back strobes: only the second should be displayed.
        e.d0 = exp_d0(4'd9, 1'b0);
        e.d1 = exp_d1(5'b01001, 1'b0);
        sb.push_back(e);
        in_valid = 1'b1;
        product  = 5'b00011;
        tick();
        chk("rv_b2b_first", 16'(result_valid), 16'd1);
        product = 5'b01001;
        tick();
        in_valid = 1'b0;
        tick();
        chk("seg_b2b_n1", 16'(seg), 16'((an == 2'b10) ? e.d0 : e.d1));
        idle(SETTLE);
        observe(16);

        rst = 1'b1;
        tick();
        chk("rst_show_seg", 16'(seg), 16'h7f);
        chk("rst_show_an", 16'(an), 16'h3);
        chk("rst_show_rv", 16'(result_valid), 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_blank", {7'd0, seg, an}, {7'd0, 7'h7f, 2'b11});
        end

`ifdef RESULT_BLINK_EN
        in_valid = 1'b1;
        product  = 5'b00100;
        tick();
        in_valid = 1'b0;
        chk("blink_rv_capture", 16'(result_valid), 16'd1);
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk("blink_an_off", 16'(an == 2'b11),
                16'(((k >= 9) && (k <= 16)) || ((k >= 25) && (k <= 32))));
            chk("blink_rv", 16'(result_valid), 16'd1);
        end
`endif

        chk("sb_drained", 16'(sb.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
